// File: rtl/fetch_credit_scheduler_if.sv
// Fetch request/response handshake between the scheduler and the
// instruction memory port.
interface fetch_credit_scheduler_if;
    logic        oFETCH_REQ;
    logic [31:0] oFETCH_ADDR;
    logic        iFETCH_BUSY;
    logic        iFETCH_VALID;

    modport master (
        output oFETCH_REQ,
        output oFETCH_ADDR,
        input  iFETCH_BUSY,
        input  iFETCH_VALID
    );

    modport slave (
        input  oFETCH_REQ,
        input  oFETCH_ADDR,
        output iFETCH_BUSY,
        output iFETCH_VALID
    );
endinterface

// File: rtl/fetch_credit_scheduler.sv
// Credit-limited sequential fetch into the loop buffer, with redirect
// flush and discard of responses that were in flight at redirect time.
module fetch_credit_scheduler #(
    parameter int P_DEPTH   = 32,
    parameter int P_CNT_W   = 6,
    parameter int P_MAX_OUT = 4,
    parameter int P_OUT_W   = 3
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iRESTART_VALID,
    input  logic [31:0]          iRESTART_PC,
    input  logic [P_CNT_W-1:0]   iBUFFER_COUNT,
    output logic                 oBUFFER_FLUSH,
    fetch_credit_scheduler_if.master fetch,
    output logic                 oRESP_VALID,
    output logic [31:0]          oRESP_PC,
    output logic [P_OUT_W-1:0]   oOUTSTANDING,
    output logic                 oPROTOCOL_ERROR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [P_CNT_W:0]   LP_DEPTH = (P_CNT_W+1)'(P_DEPTH);
    localparam logic [P_OUT_W-1:0] LP_MAX   = P_OUT_W'(P_MAX_OUT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_resp_pc;
    logic [P_OUT_W-1:0] r_out;
    logic [P_OUT_W-1:0] r_discard;
    logic               r_flush;
    logic               r_perr;

    logic [31:0]        w_target;
    logic [P_CNT_W:0]   w_sum;
    logic               w_credit_ok;
    logic               w_rsp;
    logic               w_acc;
    logic               w_req;
    logic               w_rvalid;
    logic [P_OUT_W-1:0] w_out_nxt;
    logic [P_OUT_W-1:0] w_dis_nxt;

    assign w_target = {iRESTART_PC[31:2], 2'b00};
    // one extra bit so occupancy + outstanding can never wrap
    assign w_sum = {1'b0, iBUFFER_COUNT}
                 + {{(P_CNT_W+1-P_OUT_W){1'b0}}, r_out};
    assign w_credit_ok = (r_out < LP_MAX) && (w_sum < LP_DEPTH);
    assign w_rsp = fetch.iFETCH_VALID && (r_out != '0);
    assign w_acc = w_req && !fetch.iFETCH_BUSY;

    always_comb begin
        w_out_nxt = r_out;
        if (w_acc && !w_rsp)
            w_out_nxt = r_out + 1'b1;
        else if (!w_acc && w_rsp)
            w_out_nxt = r_out - 1'b1;
    end

    always_comb begin
        w_dis_nxt = r_discard;
        if (w_rsp && r_discard != '0)
            w_dis_nxt = r_discard - 1'b1;
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:
                if (iRESTART_VALID)
                    w_state_nxt = S_RUN;
            S_RUN:
                if (iRESTART_VALID && w_out_nxt != '0)
                    w_state_nxt = S_DRAIN;
            S_DRAIN:
                // a redirect on the last discard leaves nothing to drain
                if (w_dis_nxt == '0)
                    w_state_nxt = S_RUN;
            default:
                w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_req    = 1'b0;
        w_rvalid = 1'b0;
        if (r_state == S_RUN) begin
            w_req    = !r_flush && !iRESTART_VALID && w_credit_ok;
            w_rvalid = w_rsp;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_fetch_pc <= '0;
            r_resp_pc  <= '0;
            r_out      <= '0;
            r_discard  <= '0;
            r_flush    <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_flush <= iRESTART_VALID;
            r_out   <= w_out_nxt;
            if (fetch.iFETCH_VALID && r_out == '0)
                r_perr <= 1'b1;
            if (iRESTART_VALID) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
            end else begin
                if (w_acc)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_rvalid)
                    r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (r_state == S_DRAIN)
                r_discard <= w_dis_nxt;
            else if (r_state == S_RUN && iRESTART_VALID)
                r_discard <= w_out_nxt;
            else
                r_discard <= '0;
        end
    end

    assign fetch.oFETCH_REQ  = w_req;
    assign fetch.oFETCH_ADDR = r_fetch_pc;
    assign oBUFFER_FLUSH     = r_flush;
    assign oRESP_VALID       = w_rvalid;
    assign oRESP_PC          = r_resp_pc;
    assign oOUTSTANDING      = r_out;
    assign oPROTOCOL_ERROR   = r_perr;

endmodule

// File: tb/tb_fetch_credit_scheduler.sv
// Randomized scoreboard bench for fetch_credit_scheduler against an
// in-flight queue model of the fetch/discard rules.
module tb_fetch_credit_scheduler;

    logic        clk;
    logic        rst_n;
    logic        restart;
    logic [31:0] restart_pc;
    logic [5:0]  buf_count;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic [2:0]  outstanding;
    logic        perr;

    fetch_credit_scheduler_if u_if ();

    fetch_credit_scheduler dut (
        .iCLOCK          (clk),
        .inRESET         (rst_n),
        .iRESTART_VALID  (restart),
        .iRESTART_PC     (restart_pc),
        .iBUFFER_COUNT   (buf_count),
        .oBUFFER_FLUSH   (flush),
        .fetch           (u_if),
        .oRESP_VALID     (resp_valid),
        .oRESP_PC        (resp_pc),
        .oOUTSTANDING    (outstanding),
        .oPROTOCOL_ERROR (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit chk;
        bit flush;
        bit req;
        bit rv;
        int out;
        bit perr;
    } exp_t;

    exp_t        sb_st[$];
    logic [31:0] sb_resp[$];
    logic [31:0] sb_acc[$];

    // model: in-flight queue of stale flags, oldest first
    bit          m_q[$];
    bit          m_run;
    bit          m_flush;
    bit          m_perr;
    logic [31:0] m_fpc;
    logic [31:0] m_rpc;
    int          buf_nxt;
    bit          drain_en;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    function automatic bit stale_front();
        return m_q.size() > 0 && m_q[0];
    endfunction

    task automatic cycle(input bit rst, input bit rs,
                         input logic [31:0] pc,
                         input bit busy, input bit fv);
        exp_t e;
        bit   req;
        bit   acc;
        bit   rv;
        @(posedge clk);
        #1;
        rst_n = rst;
        restart = rs;
        restart_pc = pc;
        u_if.iFETCH_BUSY = busy;
        u_if.iFETCH_VALID = fv;
        buf_count = 6'(buf_nxt);
        req = m_run && !m_flush && !rs && !stale_front()
              && m_q.size() < 4 && (buf_nxt + m_q.size() < 32);
        acc = req && !busy;
        rv = fv && m_q.size() > 0 && !m_q[0];
        e.chk = rst;
        e.flush = m_flush;
        e.req = req;
        e.rv = rv;
        e.out = m_q.size();
        e.perr = m_perr;
        sb_st.push_back(e);
        if (!rst) begin
            m_q.delete();
            m_run = 0;
            m_flush = 0;
            m_perr = 0;
            m_fpc = 0;
            m_rpc = 0;
            buf_nxt = 0;
        end else begin
            if (fv) begin
                if (m_q.size() == 0) begin
                    m_perr = 1;
                end else begin
                    if (!m_q[0]) begin
                        sb_resp.push_back(m_rpc);
                        m_rpc = m_rpc + 4;
                    end
                    void'(m_q.pop_front());
                end
            end
            if (acc) begin
                sb_acc.push_back(m_fpc);
                m_q.push_back(1'b0);
                m_fpc = m_fpc + 4;
            end
            if (rs) begin
                foreach (m_q[i]) m_q[i] = 1'b1;
                m_fpc = {pc[31:2], 2'b00};
                m_rpc = {pc[31:2], 2'b00};
                m_run = 1;
            end
            // loop buffer: cleared by the flush pulse, filled by responses
            if (m_flush)
                buf_nxt = 0;
            else if (rv)
                buf_nxt = buf_nxt + 1;
            if (drain_en && buf_nxt > 0 && $urandom_range(0, 2) == 0)
                buf_nxt = buf_nxt - 1;
            m_flush = rs;
        end
    endtask

    task automatic rand_cycle(input int rs_div, input bit stray);
        bit          rs;
        bit          busy;
        bit          fv;
        logic [31:0] pc;
        rs = rs_div > 0 && $urandom_range(0, rs_div - 1) == 0;
        pc = $urandom;
        busy = $urandom_range(0, 3) == 0;
        if (m_q.size() > 0)
            fv = $urandom_range(0, 1) == 1;
        else
            fv = stray && $urandom_range(0, 29) == 0;
        cycle(1'b1, rs, pc, busy, fv);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] x;
        if (sb_st.size() > 0) begin
            e = sb_st.pop_front();
            if (e.chk) begin
                check("flush", 32'(flush), 32'(e.flush));
                check("fetch_req", 32'(u_if.oFETCH_REQ), 32'(e.req));
                check("resp_valid", 32'(resp_valid), 32'(e.rv));
                check("outstanding", 32'(outstanding), e.out);
                check("proto_err", 32'(perr), 32'(e.perr));
                check("credit", 32'(int'(outstanding) + int'(buf_count) <= 32),
                      32'd1);
                if (resp_valid) begin
                    if (sb_resp.size() == 0) begin
                        check("resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        x = sb_resp.pop_front();
                        check("resp_pc", resp_pc, x);
                    end
                end
                if (u_if.oFETCH_REQ && !u_if.iFETCH_BUSY) begin
                    if (sb_acc.size() == 0) begin
                        check("req_unexpected", 32'd1, 32'd0);
                    end else begin
                        x = sb_acc.pop_front();
                        check("fetch_addr", u_if.oFETCH_ADDR, x);
                    end
                end
            end
        end
    end

    initial begin
        int k;
        rst_n = 1'b0;
        restart = 1'b0;
        restart_pc = '0;
        buf_count = '0;
        buf_nxt = 0;
        drain_en = 0;
        u_if.iFETCH_BUSY = 1'b1;
        u_if.iFETCH_VALID = 1'b0;
        m_run = 0;
        m_flush = 0;
        m_perr = 0;
        m_fpc = 0;
        m_rpc = 0;

        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 32'h1000, 1'b0, 1'b0);

        // buffer never drained: credit limit must stop issue
        repeat (400) rand_cycle(0, 1'b0);
        drain_en = 1;
        repeat (1500) rand_cycle(40, 1'b0);

        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // empty the pipe, then a stray response
        k = 0;
        while (m_q.size() > 0 && k < 100) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            k++;
        end
        check("drain_timeout", 32'(m_q.size()), 32'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (300) rand_cycle(40, 1'b1);

        // build up requests, redirect, reset while draining
        cycle(1'b1, 1'b1, 32'h3000, 1'b1, 1'b0);
        k = 0;
        while (!(m_q.size() >= 3 && !stale_front()) && k < 200) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0, stale_front());
            k++;
        end
        check("fill_timeout", 32'(m_q.size() >= 3), 32'd1);
        cycle(1'b1, 1'b1, 32'h2002, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        cycle(1'b1, 1'b1, 32'h2002, 1'b0, 1'b0);
        repeat (300) rand_cycle(30, 1'b0);

        @(negedge clk);
        #1;
        check("resp_left", 32'(sb_resp.size()), 32'd0);
        check("acc_left", 32'(sb_acc.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_credit_scheduler.md
Name: fetch_credit_scheduler

Overview:
- Sequences instruction-fetch requests into the 32-entry instruction loop buffer.
- Issues sequential fetch addresses and tracks in-flight requests.
- Guarantees buffer occupancy plus outstanding requests never exceeds buffer depth, so the buffer write side never sees a full condition.
- On a PC redirect: flushes the buffer, discards stale responses still in flight, then restarts fetch at the new PC.

Parameters:
- P_DEPTH, 32, loop-buffer entry count; credit limit for occupancy+outstanding.
- P_CNT_W, 6, width of the buffer occupancy input; must hold 0..P_DEPTH.
- P_MAX_OUT, 4, maximum outstanding fetch requests.
- P_OUT_W, 3, width of the outstanding counter; must hold 0..P_MAX_OUT.

Ports:
- iCLOCK  in  1  clock; all state updates on rising edge.
- inRESET  in  1  reset, synchronous, active-low.
- iRESTART_VALID  in  1  redirect request; single-cycle, may repeat.
- iRESTART_PC  in  32  redirect target; bits [1:0] ignored, treated as 0.
- iBUFFER_COUNT  in  P_CNT_W  current loop-buffer occupancy (zero-extended).
- oBUFFER_FLUSH  out  1  one-cycle pulse to the loop-buffer refresh input.
- oFETCH_REQ  out  1  fetch request valid.
- oFETCH_ADDR  out  32  fetch address; word aligned.
- iFETCH_BUSY  in  1  memory side stall; request accepted iff oFETCH_REQ && !iFETCH_BUSY.
- iFETCH_VALID  in  1  fetch response strobe; responses return in request order.
- oRESP_VALID  out  1  forward response into buffer (drives buffer's inst-valid).
- oRESP_PC  out  32  PC associated with the current response.
- oOUTSTANDING  out  P_OUT_W  in-flight request count.
- oPROTOCOL_ERROR  out  1  sticky; response received with zero outstanding.

Behaviour:
- Reset (inRESET=0 at edge):
  - state=IDLE; fetch_pc=0, resp_pc=0, outstanding=0, discard=0.
  - oBUFFER_FLUSH=0, oFETCH_REQ=0, oRESP_VALID=0, oPROTOCOL_ERROR=0.
  - Reset overrides every other input in that cycle, including mid-DRAIN.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - No requests issued.
  - iRESTART_VALID: fetch_pc and resp_pc <= {iRESTART_PC[31:2],2'b00}; oBUFFER_FLUSH <= 1; go RUN.
  - iFETCH_VALID in IDLE is a protocol error; ignored.
- RUN:
  - oFETCH_REQ = !oBUFFER_FLUSH && !iRESTART_VALID && (outstanding < P_MAX_OUT) && (iBUFFER_COUNT + outstanding < P_DEPTH).
  - Sum is computed at P_CNT_W+1 bits, so no wrap is possible.
  - Gating on oBUFFER_FLUSH blocks issue in the cycle where the occupancy input is stale.
  - oFETCH_ADDR = fetch_pc (combinational from the register).
  - Accept: fetch_pc <= fetch_pc + 4, wrapping 32'hFFFFFFFC -> 0; outstanding++.
  - Response: oRESP_VALID = iFETCH_VALID (combinational); oRESP_PC = resp_pc; resp_pc += 4; outstanding--.
  - Accept and response in the same cycle: outstanding unchanged; both PCs advance.
- Redirect in RUN (iRESTART_VALID=1):
  - No request in that cycle.
  - A response arriving in the same cycle is still forwarded (it precedes the flush pulse).
  - Both PCs load the target; oBUFFER_FLUSH <= 1.
  - Let n = outstanding after this cycle's response. n>0: discard <= n, go DRAIN. n=0: stay RUN.
- DRAIN:
  - oFETCH_REQ=0; oRESP_VALID forced 0.
  - Each iFETCH_VALID decrements both discard and outstanding.
  - Response when discard==1: go RUN next cycle.
  - iRESTART_VALID in DRAIN: reload both PCs and re-pulse oBUFFER_FLUSH; stay DRAIN. A response in that same cycle still counts as a discard.
- oBUFFER_FLUSH is a registered pulse, high for exactly one cycle after each restart cycle. Back-to-back restarts give back-to-back pulses.
- oPROTOCOL_ERROR is set when iFETCH_VALID arrives with outstanding==0. The stray response is not forwarded, and outstanding stays 0 (no underflow). The flag clears only on reset.
- Outstanding never exceeds P_MAX_OUT; iBUFFER_COUNT + outstanding never exceeds P_DEPTH.

Test Plan:
- Reset, restart PC=0x1000, iFETCH_BUSY=0, memory returns 2 cycles later, buffer never drained:
  - flush pulse 1 cycle after restart.
  - Addresses issued 0x1000,0x1004,...
  - Outstanding caps at 4.
  - Issue stops once count+outstanding=32.
  - Resumes when count drops to 31.
- iFETCH_BUSY=1 for 5 cycles while oFETCH_REQ=1:
  - oFETCH_ADDR held at 0x1010.
  - Outstanding unchanged.
  - Single issue after busy drops.
- Redirect to 0x2002 with 3 outstanding:
  - State goes DRAIN.
  - Next 3 responses produce oRESP_VALID=0.
  - Then first request at 0x2000; next forwarded response has oRESP_PC=0x2000.
- Redirect coincident with a response, 1 outstanding:
  - That response is forwarded with the old PC.
  - Goes directly to RUN.
  - Next request at the new target.
- Second redirect during DRAIN, 2 left:
  - Two flush pulses total.
  - Fetch resumes at the second target after 2 discards.
- iFETCH_VALID with 0 outstanding, and reset asserted mid-DRAIN:
  - oPROTOCOL_ERROR=1, outstanding stays 0.
  - After reset: IDLE, all outputs 0.
